// File: rtl/led_status_array.sv
// N-channel front-panel status LED driver: LINK/ACT per channel select off, solid
// or blinking, with one shared tick prescaler and blink phase across all channels.
module led_status_array #(
    parameter int NumLeds      = 8,
    parameter int TickDiv      = 250000,
    parameter int StretchTicks = 50,
    parameter int BlinkTicks   = 25
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NumLeds-1:0] LINK,
    input  logic [NumLeds-1:0] ACT,
    input  logic [NumLeds-1:0] EN,
    input  logic               TEST,
    output logic [NumLeds-1:0] LED,
    output logic               TICK
);

    localparam int PW = $clog2(TickDiv + 1);
    localparam int SW = $clog2(StretchTicks + 1);
    localparam int BW = $clog2(BlinkTicks + 1);

    localparam logic [PW-1:0] PRESC_LAST   = PW'(TickDiv - 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(StretchTicks);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BlinkTicks - 1);

    logic [PW-1:0]              presc_q, presc_d;
    logic                       tick_q, tick_d;
    logic [BW-1:0]              blink_cnt_q, blink_cnt_d;
    logic                       phase_q, phase_d;
    logic [NumLeds-1:0][SW-1:0] stretch_q, stretch_d;
    logic [NumLeds-1:0]         led_q, led_d;

    // Prescaler: the strobe is registered, so it lands one cycle after the last count.
    always_comb begin
        tick_d  = (presc_q == PRESC_LAST);
        presc_d = tick_d ? '0 : presc_q + PW'(1);
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (tick_q) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // LED uses the post-update window and phase so it tracks inputs with one cycle of latency.
    always_comb begin
        stretch_d = stretch_q;
        led_d     = '0;
        for (int i = 0; i < NumLeds; i++) begin
            if (!LINK[i]) begin
                stretch_d[i] = '0;
            end else if (ACT[i]) begin
                stretch_d[i] = STRETCH_LOAD;
            end else if (tick_q && (stretch_q[i] != '0)) begin
                stretch_d[i] = stretch_q[i] - SW'(1);
            end

            if (TEST) begin
                led_d[i] = 1'b1;
            end else if (!EN[i] || !LINK[i]) begin
                led_d[i] = 1'b0;
            end else if (stretch_d[i] != '0) begin
                led_d[i] = phase_d;
            end else begin
                led_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q     <= '0;
            tick_q      <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            stretch_q   <= '0;
            led_q       <= '0;
        end else begin
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            stretch_q   <= stretch_d;
            led_q       <= led_d;
        end
    end

    assign LED  = led_q;
    assign TICK = tick_q;

endmodule

// File: tb/tb_led_status_array.sv
// Bench for led_status_array: per-cycle scoreboard against a behavioural model,
// a table of static-priority vectors, and hand-derived multi-cycle sequences.
module tb_led_status_array;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int BT = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] link, act, en;
    logic         test;
    logic [N-1:0] led;
    logic         tick;

    int total;
    int bad;

    logic [N:0] exp_q[$];

    int       m_presc;
    logic     m_tick;
    int       m_bcnt;
    logic     m_phase;
    int       m_str[N];

    typedef struct {
        logic [N-1:0] link;
        logic [N-1:0] act;
        logic [N-1:0] en;
        logic         test;
        logic [N-1:0] exp_led;
    } vec_t;

    vec_t vecs[10];

    led_status_array #(
        .NumLeds(N), .TickDiv(TD), .StretchTicks(ST), .BlinkTicks(BT)
    ) dut (
        .CLK(clk), .RST(rst), .LINK(link), .ACT(act), .EN(en),
        .TEST(test), .LED(led), .TICK(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_tick  = 1'b0;
        m_bcnt  = 0;
        m_phase = 1'b0;
        for (int i = 0; i < N; i++) m_str[i] = 0;
        exp_q.delete();
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_next();
        logic         t;
        logic [N-1:0] l;
        t = m_tick;
        if (m_presc == TD - 1) begin
            m_presc = 0;
            m_tick  = 1'b1;
        end else begin
            m_presc = m_presc + 1;
            m_tick  = 1'b0;
        end
        if (t) begin
            if (m_bcnt == BT - 1) begin
                m_bcnt  = 0;
                m_phase = ~m_phase;
            end else begin
                m_bcnt = m_bcnt + 1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!link[i]) m_str[i] = 0;
            else if (act[i]) m_str[i] = ST;
            else if (t && m_str[i] > 0) m_str[i] = m_str[i] - 1;
            if (test) l[i] = 1'b1;
            else if (!en[i] || !link[i]) l[i] = 1'b0;
            else if (m_str[i] > 0) l[i] = m_phase;
            else l[i] = 1'b1;
        end
        exp_q.push_back({l, m_tick});
    endtask

    task automatic sb_check();
        logic [N:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("sb_led_tick", {27'd0, led, tick}, {27'd0, e});
        end
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        sb_check();
    endtask

    // Leaves the bench at a negedge with reset released; the next posedge is edge 1.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_led", {28'd0, led}, 32'd0);
        chk("reset_tick", {31'd0, tick}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        link  = '0;
        act   = '0;
        en    = '1;
        test  = 1'b0;

        vecs[0] = '{link: 4'h0, act: 4'h0, en: 4'hF, test: 1'b0, exp_led: 4'h0};
        vecs[1] = '{link: 4'hF, act: 4'h0, en: 4'hF, test: 1'b0, exp_led: 4'hF};
        vecs[2] = '{link: 4'hF, act: 4'h0, en: 4'h5, test: 1'b0, exp_led: 4'h5};
        vecs[3] = '{link: 4'h3, act: 4'h0, en: 4'hF, test: 1'b0, exp_led: 4'h3};
        vecs[4] = '{link: 4'h0, act: 4'h0, en: 4'h0, test: 1'b1, exp_led: 4'hF};
        vecs[5] = '{link: 4'h0, act: 4'h0, en: 4'h0, test: 1'b0, exp_led: 4'h0};
        vecs[6] = '{link: 4'h0, act: 4'hF, en: 4'hF, test: 1'b0, exp_led: 4'h0};
        vecs[7] = '{link: 4'hF, act: 4'h0, en: 4'hF, test: 1'b0, exp_led: 4'hF};
        vecs[8] = '{link: 4'hA, act: 4'h0, en: 4'hF, test: 1'b1, exp_led: 4'hF};
        vecs[9] = '{link: 4'hF, act: 4'h0, en: 4'h0, test: 1'b0, exp_led: 4'h0};

        // Prescaler after release: LINK low, TICK on edges 4, 8, 12.
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("tick_period", {31'd0, tick}, {31'd0, (k % 4) == 0});
            chk("link_down_led", {28'd0, led}, 32'd0);
        end

        // Static priorities: TEST over EN over LINK; ACT while link down opens nothing.
        do_reset();
        for (int v = 0; v < 10; v++) begin
            link = vecs[v].link;
            act  = vecs[v].act;
            en   = vecs[v].en;
            test = vecs[v].test;
            step();
            chk($sformatf("vec%0d_led", v), {28'd0, led}, {28'd0, vecs[v].exp_led});
        end
        act  = '0;
        en   = '1;
        test = 1'b0;

        // Single ACT[0] pulse on edge 1: window spans edges 1..12, phase is 0 until edge 9.
        do_reset();
        link = '1;
        act  = 4'h1;
        for (int k = 1; k <= 16; k++) begin
            step();
            act = '0;
            chk("act_pulse_led", {28'd0, led}, (k <= 8) ? 32'hE : 32'hF);
        end

        // ACT[1] held for edges 1..40: phase flips every 8 edges, window ends after edge 48.
        do_reset();
        link = '1;
        act  = 4'h2;
        for (int k = 1; k <= 56; k++) begin
            logic ph;
            if (k == 41) act = '0;
            step();
            ph = ((k - 1) >> 3) & 1;
            chk("act_held_led", {28'd0, led}, (k <= 48) ? {28'd0, 1'b1, 1'b1, ph, 1'b1} : 32'hF);
        end

        // LINK[2] drop one tick into a window; reassert must not resume it (phase is 0 then).
        do_reset();
        link = '1;
        for (int k = 1; k <= 44; k++) begin
            act  = (k == 31) ? 4'h4 : 4'h0;
            link = (k == 34) ? 4'hB : 4'hF;
            step();
            chk("link_drop_led", {28'd0, led}, (k == 33 || k == 34) ? 32'hB : 32'hF);
        end
        act  = '0;
        link = '1;

        // Asynchronous reset in the middle of an active window.
        do_reset();
        link = '1;
        for (int k = 1; k <= 10; k++) begin
            act = (k == 9) ? 4'h1 : 4'h0;
            step();
        end
        chk("pre_rst_led", {28'd0, led}, 32'hF);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_led", {28'd0, led}, 32'd0);
        chk("rst_async_tick", {31'd0, tick}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) act = 4'h6;
            else act = 4'h0;
            step();
            chk("post_rst_tick", {31'd0, tick}, {31'd0, (k % 4) == 0});
        end
        for (int k = 0; k < 30; k++) begin
            act  = 4'($urandom_range(0, 15));
            en   = 4'($urandom_range(0, 15));
            link = 4'($urandom_range(0, 15)) | 4'h9;
            test = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_status_array.md
Name: led_status_array

Overview:
- Parametrised N-channel front-panel status LED driver.
- Replaces the per-LED instance array in board top-levels with a single block.
- Per-channel LINK/ACT inputs drive one LED each: off (link down), solid on (link idle), or blinking for a stretched window after activity.
- Shares one prescaler and blink phase across all channels, so every blinking LED toggles in lockstep.

Parameters:
- NumLeds, 8, number of channels/LEDs (>=1).
- TickDiv, 250000, CLK cycles per tick (>=1; 1 ms at 250 MHz).
- StretchTicks, 50, ticks an activity window stays open after the last ACT cycle (>=1).
- BlinkTicks, 25, ticks per blink half-period (>=1).

Ports:
- CLK  in  1  system clock (PCIe user clock domain).
- RST  in  1  asynchronous, active-high reset.
- LINK  in  NumLeds  per-channel link-up level, synchronous to CLK.
- ACT  in  NumLeds  per-channel activity: any cycle high counts as traffic.
- EN  in  NumLeds  per-channel enable; 0 forces that LED off.
- TEST  in  1  lamp test; 1 forces all LEDs on, overriding EN.
- LED  out  NumLeds  registered LED drive, 1 = lit.
- TICK  out  1  one-cycle tick strobe, for debug and sharing.

Behaviour:
- Clock and reset: one clock, CLK; reset RST is asynchronous and active-high. All flops clear on RST assertion, independent of CLK.
- Reset values: LED = 0, TICK = 0, prescaler = 0, blink counter = 0, blink phase = 0, all stretch counters = 0.
- Prescaler:
  - Counts 0..TickDiv-1, then wraps to 0.
  - TICK is registered and high for exactly the one cycle after the count equals TickDiv-1.
  - Period is TickDiv cycles. With TickDiv=1, TICK is high on every cycle after reset release.
- Blink generator:
  - On each TICK cycle the blink counter increments.
  - When it reaches BlinkTicks-1 and a TICK occurs, it wraps to 0 and the phase toggles.
  - Full blink period = 2*BlinkTicks ticks.
- Stretch counter, per channel i, priority order:
  1. LINK[i]=0: clear to 0.
  2. Else ACT[i]=1: load StretchTicks. This wins over a simultaneous TICK decrement.
  3. Else TICK=1 and counter>0: decrement by 1.
  4. Otherwise hold. The counter saturates at 0.
- Counter widths are $clog2(param+1), so there is no wrap-around.
- LED[i] next-state, priority order:
  1. TEST=1: 1.
  2. EN[i]=0: 0.
  3. LINK[i]=0: 0.
  4. Stretch counter (post-update) > 0: blink phase (post-update).
  5. Otherwise: 1.
- Latency: LED reflects inputs one cycle after they are sampled.
- An ACT pulse while LINK=0 is ignored; no window opens.
- A LINK drop during a window kills the window immediately, and the LED goes off on the next cycle.
- Continuous ACT holds the window open indefinitely; the LED keeps blinking.
- EN=0 does not clear the stretch counter. Re-enabling mid-window resumes blinking.
- TEST does not disturb any internal state.
- Reset asserted mid-operation: LED drops to 0 asynchronously. After release, the prescaler and blink phase restart from 0.
- Channels are fully independent except for the shared tick and phase. Channel count has no effect on timing.

Test Plan:
- All tests use NumLeds=4, TickDiv=4, StretchTicks=3, BlinkTicks=2.
- Reset, then release with LINK=0, EN=F, TEST=0:
  - LED=0 throughout.
  - TICK pulses every 4 cycles; first pulse on the 4th cycle after release.
- LINK=F, EN=F, ACT=0:
  - LED=F one cycle after LINK rises.
  - Stays F with no blinking.
- LINK=F, single-cycle ACT[0] pulse:
  - LED[0] follows blink phase for exactly 3 ticks (12 cycles, ±tick alignment), then returns to 1.
  - LED[3:1] stay 1.
- ACT[1] held high for 40 cycles, then dropped:
  - LED[1] toggles every 8 cycles while ACT is held and for 3 ticks after.
  - Then solid 1.
- LINK[2] dropped one tick into an ACT[2] window:
  - LED[2]=0 next cycle.
  - When LINK[2] is reasserted, LED[2]=1 solid; the old window is not resumed.
- TEST=1 with LINK=0, EN=0:
  - LED=F next cycle.
  - When TEST is deasserted, LED=0.
  - Pulsing RST mid-window clears LED to 0 asynchronously, within the same cycle.
